// File: rtl/mem_fill_mc.sv
// rtl/mem_fill_mc.sv - multi-channel ping-pong frame buffer; status read path enabled by MEM_FILL_MC_HDR_EN
module mem_fill_mc #(
    parameter int CH_NUM = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 10,
    parameter int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
`ifdef MEM_FILL_MC_HDR_EN
    localparam int RA_W  = CH_W + CNT_W + 1
`else
    localparam int RA_W  = CH_W + CNT_W
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM*DATA_W-1:0] i_ch_data,
    input  logic [CH_NUM-1:0]        i_ch_vld,
    input  logic [CH_NUM*CNT_W-1:0]  i_ch_cntr,
    input  logic                     i_msync_n,
    input  logic [RA_W-1:0]          i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_rd_bank,
    output logic [15:0]              o_frame_cnt,
    output logic [CH_NUM-1:0]        o_drop
);
    localparam int MA_W  = 1 + CH_W + CNT_W;
    localparam int DEPTH = 1 << MA_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] r_hold_data [CH_NUM];
    logic [CNT_W-1:0]  r_hold_cntr [CH_NUM];
    logic [CH_NUM-1:0] r_hold_tag;
    logic [CH_NUM-1:0] r_hold_full;

    logic              r_wr_bank;
    logic [CH_W-1:0]   r_rr_ptr;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync3;
    logic [15:0]       r_frame_cnt;
    logic [CH_NUM-1:0] r_drop_acc;
    logic [CH_NUM-1:0] r_drop;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_fall;
    logic              w_new_tag;
    logic              w_gnt_vld;
    logic [CH_W-1:0]   w_gnt_ch;
    logic [CH_W-1:0]   w_idx;
    logic [CH_NUM-1:0] w_gnt;
    logic [CH_NUM-1:0] w_drop;
    logic [MA_W-1:0]   w_wr_addr;
    logic [MA_W-1:0]   w_rd_addr;

    // Words captured on the swap edge already belong to the new frame
    assign w_fall    = r_sync3 & ~r_sync2;
    assign w_new_tag = r_wr_bank ^ w_fall;

    // Scan downwards so the full entry nearest the pointer wins
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        w_idx     = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            w_idx = CH_W'((int'(r_rr_ptr) + i) % CH_NUM);
            if (r_hold_full[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = w_idx;
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_gnt_vld) begin
            w_gnt[w_gnt_ch] = 1'b1;
        end
    end

    assign w_drop    = i_ch_vld & r_hold_full & ~w_gnt;
    assign w_wr_addr = {r_hold_tag[w_gnt_ch], w_gnt_ch, r_hold_cntr[w_gnt_ch]};
    assign w_rd_addr = {~r_wr_bank, i_rd_addr[CH_W+CNT_W-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_full <= '0;
            r_hold_tag  <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                r_hold_data[k] <= '0;
                r_hold_cntr[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CH_NUM; k++) begin
                if (i_ch_vld[k] && !w_drop[k]) begin
                    r_hold_full[k] <= 1'b1;
                    r_hold_tag[k]  <= w_new_tag;
                    r_hold_data[k] <= i_ch_data[k*DATA_W +: DATA_W];
                    r_hold_cntr[k] <= i_ch_cntr[k*CNT_W +: CNT_W];
                end else if (w_gnt[k]) begin
                    r_hold_full[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_gnt_vld && !rst) begin
            r_mem[w_wr_addr] <= r_hold_data[w_gnt_ch];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync3     <= 1'b1;
            r_wr_bank   <= 1'b0;
            r_rr_ptr    <= '0;
            r_frame_cnt <= '0;
            r_drop_acc  <= '0;
            r_drop      <= '0;
        end else begin
            r_sync1 <= i_msync_n;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (w_gnt_vld) begin
                r_rr_ptr <= (w_gnt_ch == CH_W'(CH_NUM - 1)) ? '0 : w_gnt_ch + CH_W'(1);
            end
            if (w_fall) begin
                r_wr_bank   <= ~r_wr_bank;
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_drop      <= r_drop_acc;
                r_drop_acc  <= w_drop;
            end else begin
                r_drop_acc  <= r_drop_acc | w_drop;
            end
        end
    end

`ifdef MEM_FILL_MC_HDR_EN
    localparam int SW = (DATA_W > 32) ? DATA_W : 32;
    logic [SW-1:0]     w_status_ext;
    logic [DATA_W-1:0] w_status;
    assign w_status_ext = SW'({r_frame_cnt, 16'(r_drop)});
    assign w_status     = w_status_ext[DATA_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
`ifdef MEM_FILL_MC_HDR_EN
        end else if (i_rd_addr[RA_W-1]) begin
            r_rd_data <= w_status;
`endif
        end else begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_rd_bank   = ~r_wr_bank;
    assign o_frame_cnt = r_frame_cnt;
    assign o_drop      = r_drop;

endmodule

// File: tb/tb_mem_fill_mc.sv
// tb/tb_mem_fill_mc.sv - randomized self-checking bench for mem_fill_mc against a per-bank memory model
module tb_mem_fill_mc;
    localparam int CH_NUM = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 10;
    localparam int CH_W   = 2;
`ifdef MEM_FILL_MC_HDR_EN
    localparam int RA_W   = CH_W + CNT_W + 1;
`else
    localparam int RA_W   = CH_W + CNT_W;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [CH_NUM*DATA_W-1:0] i_ch_data;
    logic [CH_NUM-1:0]        i_ch_vld;
    logic [CH_NUM*CNT_W-1:0]  i_ch_cntr;
    logic                     i_msync_n;
    logic [RA_W-1:0]          i_rd_addr;
    logic [DATA_W-1:0]        o_rd_data;
    logic                     o_rd_bank;
    logic [15:0]              o_frame_cnt;
    logic [CH_NUM-1:0]        o_drop;

    mem_fill_mc #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_ch_data(i_ch_data), .i_ch_vld(i_ch_vld),
        .i_ch_cntr(i_ch_cntr), .i_msync_n(i_msync_n), .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data), .o_rd_bank(o_rd_bank), .o_frame_cnt(o_frame_cnt),
        .o_drop(o_drop)
    );

    always #5 clk = ~clk;

    // Reference model: RAM per bank, current write bank, frame count, drop flags
    logic [DATA_W-1:0] m_mem [int];
    logic              m_bank;
    logic [15:0]       m_fcnt;
    logic [CH_NUM-1:0] m_drop;
    logic [CH_NUM-1:0] m_drop_acc;
    logic [CH_NUM-1:0] drop_mask;
    int                sync_cd;
    int                n_checks;
    int                n_err;
    int                since [CH_NUM];
    int                rq [$];
    logic [CNT_W-1:0]  cn;

    function automatic int key(logic b, int ch, logic [CNT_W-1:0] c);
        return (int'(b) << (CH_W + CNT_W)) | (ch << CNT_W) | int'(c);
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_word(int k, logic [DATA_W-1:0] d, logic [CNT_W-1:0] c);
        i_ch_data[k*DATA_W +: DATA_W] = d;
        i_ch_cntr[k*CNT_W +: CNT_W]   = c;
    endtask

    // One clock edge; the model swaps first so words on the swap edge join the new frame
    task automatic step();
        @(posedge clk);
        if (sync_cd > 0) begin
            sync_cd--;
            if (sync_cd == 0) begin
                m_bank     = !m_bank;
                m_fcnt     = m_fcnt + 16'd1;
                m_drop     = m_drop_acc;
                m_drop_acc = '0;
            end
        end
        for (int k = 0; k < CH_NUM; k++) begin
            if (i_ch_vld[k]) begin
                if (drop_mask[k]) m_drop_acc[k] = 1'b1;
                else m_mem[key(m_bank, k, i_ch_cntr[k*CNT_W +: CNT_W])] = i_ch_data[k*DATA_W +: DATA_W];
            end
        end
        #1;
        i_ch_vld  = '0;
        drop_mask = '0;
    endtask

    task automatic rd_check(string tag, int ch, logic [CNT_W-1:0] c);
        int kk;
        kk = key(!m_bank, ch, c);
        i_rd_addr = '0;
        i_rd_addr[CH_W+CNT_W-1:0] = {CH_W'(ch), c};
        step();
        chk(tag, o_rd_data, m_mem[kk]);
    endtask

    task automatic do_sync(int low, logic [CH_NUM-1:0] v2, logic [CH_NUM-1:0] v3);
        i_msync_n = 1'b0;
        sync_cd   = 3;
        for (int i = 1; i <= low; i++) begin
            if (i == 2) i_ch_vld = v2;
            if (i == 3) i_ch_vld = v3;
            step();
            if (i == 2) chk("rd_bank_before_swap", o_rd_bank, !m_bank);
            if (i == 3) begin
                chk("rd_bank_at_swap", o_rd_bank, !m_bank);
                chk("frame_cnt", o_frame_cnt, m_fcnt);
                chk("drop", o_drop, m_drop);
            end
        end
        i_msync_n = 1'b1;
        repeat (CH_NUM + 1) step();
    endtask

    initial begin
        n_checks = 0; n_err = 0; sync_cd = 0;
        m_bank = 1'b0; m_fcnt = '0; m_drop = '0; m_drop_acc = '0; drop_mask = '0;
        rst = 1'b1; i_ch_data = '0; i_ch_vld = '0; i_ch_cntr = '0;
        i_msync_n = 1'b1; i_rd_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_rd_bank", o_rd_bank, 1'b1);
        chk("reset_frame_cnt", o_frame_cnt, 16'd0);
        chk("reset_drop", o_drop, 4'd0);
        chk("reset_rd_data", o_rd_data, 32'd0);
        repeat (2) step();

        // Single channel write and readout
        set_word(2, 32'hA5A5_0001, 10'h013);
        i_ch_vld = 4'b0100;
        step();
        repeat (3) step();
        do_sync(10, '0, '0);
        rd_check("single_rd", 2, 10'h013);

        // All channels in the same cycle
        for (int k = 0; k < CH_NUM; k++) set_word(k, 32'h10 + k, 10'h005);
        i_ch_vld = '1;
        step();
        repeat (CH_NUM + 2) step();
        do_sync(10, '0, '0);
        for (int k = 0; k < CH_NUM; k++) rd_check("simul_rd", k, 10'h005);

        // Channel 1 fires twice while the others are still pending
        for (int k = 0; k < CH_NUM; k++) set_word(k, 32'h2000 + k, 10'h020);
        i_ch_vld = '1;
        step();
        set_word(1, 32'hDEAD_0001, 10'h021);
        i_ch_vld  = 4'b0010;
        drop_mask = 4'b0010;
        step();
        repeat (6) step();
        do_sync(10, '0, '0);
        rd_check("drop_first_word", 1, 10'h020);
        do_sync(10, '0, '0);

        // Swap boundary: ch0 just before the swap edge, ch3 on it
        set_word(3, 32'h0000_01D0, 10'h055);
        i_ch_vld = 4'b1000;
        step();
        repeat (4) step();
        set_word(0, 32'hB0B0_0000, 10'h100);
        set_word(3, 32'h0000_0E3E, 10'h055);
        do_sync(10, 4'b0001, 4'b1000);
        rd_check("boundary_old_frame", 0, 10'h100);
        rd_check("boundary_not_yet", 3, 10'h055);
        do_sync(10, '0, '0);
        rd_check("boundary_next_frame", 3, 10'h055);

        // Randomized frames under the sustained-rate limit
        for (int k = 0; k < CH_NUM; k++) since[k] = CH_NUM;
        for (int f = 0; f < 6; f++) begin
            rq.delete();
            for (int c = 0; c < 40; c++) begin
                for (int k = 0; k < CH_NUM; k++) begin
                    if (since[k] >= CH_NUM && $urandom_range(0, 2) == 0) begin
                        cn = CNT_W'($urandom);
                        set_word(k, $urandom, cn);
                        i_ch_vld[k] = 1'b1;
                        since[k] = 0;
                        rq.push_back(k * (1 << CNT_W) + int'(cn));
                    end
                end
                step();
                for (int k = 0; k < CH_NUM; k++) since[k]++;
            end
            do_sync(8 + $urandom_range(0, 4), '0, '0);
            foreach (rq[i]) rd_check("rand_rd", rq[i] >> CNT_W, CNT_W'(rq[i] % (1 << CNT_W)));
        end

        // Frame counter wrap
        force dut.r_frame_cnt = 16'hFFFE;
        step();
        release dut.r_frame_cnt;
        m_fcnt = 16'hFFFE;
        do_sync(10, '0, '0);
        do_sync(10, '0, '0);
        chk("frame_cnt_wrapped", o_frame_cnt, 16'h0000);
`ifdef MEM_FILL_MC_HDR_EN
        i_rd_addr = '1;
        step();
        chk("hdr_status", o_rd_data, {m_fcnt, 16'(m_drop)});
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/mem_fill_mc.md
# mem_fill_mc

Multi-channel, ping-pong frame buffer that collects data words from the physical channel data blocks and presents one complete sync frame to the Ethernet transmitter for readout. It generalises single-channel memory filling to `CH_NUM` channels with round-robin write arbitration, bank swapping on the master sync, per-frame drop detection and a frame counter. It sits between the `data_blk` outputs, once they are retimed into the system clock domain, and the `eth_top` read port.

## Interface
Parameters:
- `CH_NUM`, 4: number of physical channels (1..8).
- `DATA_W`, 32: channel data word width.
- `CNT_W`, 10: channel word index width (`[7:0]` word number, `[9:8]` virtual channel).
- `CH_W`, `$clog2(CH_NUM)` (min 1): channel address bits.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_ch_data` in `CH_NUM*DATA_W`: channel k occupies bits `[k*DATA_W +: DATA_W]`.
- `i_ch_vld` in `CH_NUM`: one-cycle write strobe per channel, synchronous to `clk`.
- `i_ch_cntr` in `CH_NUM*CNT_W`: word index per channel.
- `i_msync_n` in 1: master sync, active low, asynchronous to `clk`.
- `i_rd_addr` in `RA_W`: read address `{hdr_sel, ch, cntr}`. `RA_W = CH_W+CNT_W+1` when `MEM_FILL_MC_HDR_EN` is defined, otherwise `CH_W+CNT_W`.
- `o_rd_data` out `DATA_W`: read data.
- `o_rd_bank` out 1: bank currently exposed to the reader.
- `o_frame_cnt` out 16: number of completed frames.
- `o_drop` out `CH_NUM`: per-channel drop flags of the last completed frame.

## Operation
- **RAM**: two banks of `CH_NUM*2^CNT_W` × `DATA_W`. Write address is `{wr_bank, ch, cntr}`; read address is `{~wr_bank, ch, cntr}`. Only the write path updates the RAM. RAM contents are not reset.
- **Hold registers**: one per channel, holding `{data, cntr, bank_tag, full}`. When `i_ch_vld[k]` is high, the hold register loads and sets `full`. If `full` is already set and the entry is not being granted that cycle, the new word is discarded and `drop_acc[k]` is set.
- **Arbiter**: round-robin over the `full` hold registers, one grant per cycle. The search starts at the channel after the last grant. A granted entry is written to bank `bank_tag` and its `full` clears. If the same channel asserts `vld` in the granted cycle, the new word loads and `full` stays set; this does not count as a drop.
- **Sync**:
  - `i_msync_n` passes through a 2-FF synchroniser, followed by a falling-edge detector.
  - On a detected fall: `wr_bank` toggles, `o_frame_cnt` increments (wraps 0xFFFF→0), `o_drop` takes `drop_acc`, and `drop_acc` clears.
  - Words captured before the swap keep their old `bank_tag` and still land in the old frame.
  - A `vld` in the swap cycle is tagged with the new bank.
  - A drop in the swap cycle goes into the new `drop_acc`.
- **Bank swap constraint**: sync low-time is at least 80 ns, and only one swap happens per falling edge, regardless of pulse width.
- `o_rd_bank` = `~wr_bank`.

## Timing
- **Reset values**:
  - `wr_bank`=0, `o_rd_bank`=1.
  - `o_frame_cnt`=0, `o_drop`=0, `drop_acc`=0, `o_rd_data`=0.
  - All `full`=0, round-robin pointer at channel 0.
  - Synchroniser flops = 1.
- **Reset mid-operation**: pending hold entries are lost and no RAM write occurs.
- **Write latency**: `vld` at edge t loads the hold register at t+1. The RAM write happens at t+2 at the earliest and at t+1+`CH_NUM` at the latest.
- **Sustained rate**: each channel's `vld` spacing must be at least `CH_NUM` cycles. Closer spacing may drop words.
- **Sync latency**: the swap occurs 3 `clk` edges after `i_msync_n` falls (2 synchroniser flops + edge register). `o_frame_cnt`, `o_drop` and `o_rd_bank` update on the same edge.
- **Read**: one-cycle latency; `o_rd_data` at t+1 reflects `i_rd_addr` and `o_rd_bank` sampled at t. A read in the swap cycle returns the pre-swap bank.
- **Collisions**: reads and writes never target the same bank in a cycle, except for late tagged writes into the just-exposed bank. These take effect within `CH_NUM` cycles of the swap, and the reader must wait `CH_NUM+1` cycles after `o_rd_bank` changes before reading.

## Configuration
- **`MEM_FILL_MC_HDR_EN` defined**:
  - `i_rd_addr` gains an MSB `hdr_sel`.
  - With `hdr_sel`=1, `o_rd_data` returns the status word `{o_frame_cnt, zero-extended o_drop}` in the low 32 bits, with the upper bits zero if `DATA_W`>32. The lower address bits are ignored.
  - With `hdr_sel`=0, behaviour is identical to the macro-undefined case.
- **Not defined**: there is no status read path and `RA_W = CH_W+CNT_W`. `o_frame_cnt` and `o_drop` remain available as ports.

## Test plan
- **Reset values**: assert `rst`, then release → `o_rd_bank`=1, `o_frame_cnt`=0, `o_drop`=0, `o_rd_data`=0.
- **Single-channel write and readout**: channel 2 writes 0xA5A5_0001 at cntr 0x013; pulse `i_msync_n` low for 10 cycles → `o_frame_cnt`=1 and `o_rd_bank`=0, 3 cycles after the fall. Reading `{ch=2, 0x013}` returns 0xA5A5_0001 one cycle later.
- **Simultaneous writes**: all 4 channels assert `vld` in the same cycle with data 0x10+k at cntr 5 → 4 writes on consecutive cycles in round-robin order; after a sync, all 4 values read back and `o_drop`=0.
- **Drop detection**: channel 1 asserts `vld` on 2 consecutive cycles while channels 0, 2 and 3 hold pending entries → the second word is dropped. After the next sync, `o_drop`=4'b0010; after the following sync, `o_drop`=0.
- **Swap boundary**: channel 0 `vld` 1 cycle before the detected fall, channel 3 `vld` on the swap cycle → channel 0's word is in the old frame (readable now). Channel 3's word appears only after the next sync.
- **Counter wrap and header**: force 65536 syncs → `o_frame_cnt` wraps to 0. With `MEM_FILL_MC_HDR_EN` defined, `hdr_sel`=1 reads `{16'h0000, 16'h0000}`.
